// File: rtl/lcd_bus_scheduler.sv
// Timed HD44780 write sequencer: runs power-on init and then shares the LCD bus
// between two requesters with round-robin arbitration.
module lcd_bus_scheduler #(
  parameter int SETUP_CYC     = 2,
  parameter int PULSE_CYC     = 10,
  parameter int HOLD_CYC      = 2,
  parameter int EXEC_CYC      = 1000,
  parameter int LONG_EXEC_CYC = 40000,
  parameter int POWERON_CYC   = 300000,
  parameter int CNT_W         = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid_i,
  input  logic       req0_rs_i,
  input  logic [7:0] req0_data_i,
  output logic       req0_ready_o,
  input  logic       req1_valid_i,
  input  logic       req1_rs_i,
  input  logic [7:0] req1_data_i,
  output logic       req1_ready_o,
  output logic       init_done_o,
  output logic       busy_o,
  output logic [7:0] lcd_data_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic       lcd_en_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_POWERON   = 3'd0,
    S_INIT_LOAD = 3'd1,
    S_SETUP     = 3'd2,
    S_PULSE     = 3'd3,
    S_HOLD      = 3'd4,
    S_EXEC      = 3'd5,
    S_IDLE      = 3'd6
  } state_e;

  // INIT_LOAD occupies the final power-on cycle so the first load edge lands
  // exactly POWERON_CYC edges after reset release (requires POWERON_CYC >= 2).
  localparam logic [CNT_W-1:0] LIM_POWERON = CNT_W'(POWERON_CYC - 2);
  localparam logic [CNT_W-1:0] LIM_SETUP   = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] LIM_PULSE   = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] LIM_HOLD    = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] LIM_EXEC    = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] LIM_LONG    = CNT_W'(LONG_EXEC_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       init_idx_q, init_idx_d;
  logic             last_grant_q, last_grant_d;
  logic [7:0]       lcd_data_q, lcd_data_d;
  logic             lcd_rs_q, lcd_rs_d;
  logic             init_done_q, init_done_d;

  logic [CNT_W-1:0] cnt_lim;
  logic             cnt_last;
  logic             long_exec;
  logic             gnt0, gnt1;
  logic [7:0]       rom_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_POWERON;
      cnt_q        <= '0;
      init_idx_q   <= '0;
      last_grant_q <= 1'b1;
      lcd_data_q   <= 8'h00;
      lcd_rs_q     <= 1'b0;
      init_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      init_idx_q   <= init_idx_d;
      last_grant_q <= last_grant_d;
      lcd_data_q   <= lcd_data_d;
      lcd_rs_q     <= lcd_rs_d;
      init_done_q  <= init_done_d;
    end
  end

  // Clear and return-home (0x01..0x03 as commands) need the long execution wait.
  assign long_exec = !lcd_rs_q && (lcd_data_q inside {8'h01, 8'h02, 8'h03});

  always_comb begin
    rom_byte = 8'h06;
    case (init_idx_q[1:0])
      2'd0:    rom_byte = 8'h38;
      2'd1:    rom_byte = 8'h0C;
      2'd2:    rom_byte = 8'h01;
      default: rom_byte = 8'h06;
    endcase
  end

  always_comb begin
    cnt_lim = '0;
    case (state_q)
      S_POWERON: cnt_lim = LIM_POWERON;
      S_SETUP:   cnt_lim = LIM_SETUP;
      S_PULSE:   cnt_lim = LIM_PULSE;
      S_HOLD:    cnt_lim = LIM_HOLD;
      S_EXEC:    cnt_lim = long_exec ? LIM_LONG : LIM_EXEC;
      default:   cnt_lim = '0;
    endcase
  end

  assign cnt_last = (cnt_q == cnt_lim);

  // On a tie the port that was not served last wins.
  assign gnt0 = req0_valid_i && (!req1_valid_i || last_grant_q);
  assign gnt1 = req1_valid_i && (!req0_valid_i || !last_grant_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    init_idx_d   = init_idx_q;
    last_grant_d = last_grant_q;
    lcd_data_d   = lcd_data_q;
    lcd_rs_d     = lcd_rs_q;
    init_done_d  = init_done_q;
    case (state_q)
      S_POWERON: begin
        if (cnt_last) state_d = S_INIT_LOAD;
        else          cnt_d   = cnt_q + 1'b1;
      end
      S_INIT_LOAD: begin
        lcd_data_d = rom_byte;
        lcd_rs_d   = 1'b0;
        init_idx_d = init_idx_q + 3'd1;
        state_d    = S_SETUP;
      end
      S_SETUP: begin
        if (cnt_last) state_d = S_PULSE;
        else          cnt_d   = cnt_q + 1'b1;
      end
      S_PULSE: begin
        if (cnt_last) state_d = S_HOLD;
        else          cnt_d   = cnt_q + 1'b1;
      end
      S_HOLD: begin
        if (cnt_last) state_d = S_EXEC;
        else          cnt_d   = cnt_q + 1'b1;
      end
      S_EXEC: begin
        if (!cnt_last) begin
          cnt_d = cnt_q + 1'b1;
        end else if (init_done_q) begin
          state_d = S_IDLE;
        end else if (init_idx_q == 3'd4) begin
          init_done_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          state_d = S_INIT_LOAD;
        end
      end
      S_IDLE: begin
        if (gnt0) begin
          lcd_data_d   = req0_data_i;
          lcd_rs_d     = req0_rs_i;
          last_grant_d = 1'b0;
          state_d      = S_SETUP;
        end else if (gnt1) begin
          lcd_data_d   = req1_data_i;
          lcd_rs_d     = req1_rs_i;
          last_grant_d = 1'b1;
          state_d      = S_SETUP;
        end
      end
      default: state_d = S_POWERON;
    endcase
  end

  // Handshake: a byte moves on a clock edge where valid && ready; ready is only
  // offered in IDLE, to at most one port, and valid must be held until then.
  assign req0_ready_o = (state_q == S_IDLE) && gnt0;
  assign req1_ready_o = (state_q == S_IDLE) && gnt1;

  assign init_done_o = init_done_q;
  assign busy_o      = (state_q != S_IDLE);
  assign lcd_data_o  = lcd_data_q;
  assign lcd_rs_o    = lcd_rs_q;
  assign lcd_rw_o    = 1'b0;
  assign lcd_en_o    = (state_q == S_PULSE);
  assign state_o     = state_q;

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Directed bench for lcd_bus_scheduler with short timing parameters; a bus
// monitor scoreboards every EN pulse against an expected byte queue.
module tb_lcd_bus_scheduler;

  localparam int SETUP   = 2;
  localparam int PULSE   = 4;
  localparam int HOLD    = 2;
  localparam int EXEC    = 8;
  localparam int LONG    = 32;
  localparam int POWERON = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_rs, req0_ready;
  logic [7:0] req0_data;
  logic       req1_valid, req1_rs, req1_ready;
  logic [7:0] req1_data;
  logic       init_done, busy;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_en;
  logic [2:0] dbg_state;

  lcd_bus_scheduler #(
    .SETUP_CYC(SETUP), .PULSE_CYC(PULSE), .HOLD_CYC(HOLD),
    .EXEC_CYC(EXEC), .LONG_EXEC_CYC(LONG), .POWERON_CYC(POWERON), .CNT_W(20)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid_i(req0_valid), .req0_rs_i(req0_rs), .req0_data_i(req0_data),
    .req0_ready_o(req0_ready),
    .req1_valid_i(req1_valid), .req1_rs_i(req1_rs), .req1_data_i(req1_data),
    .req1_ready_o(req1_ready),
    .init_done_o(init_done), .busy_o(busy),
    .lcd_data_o(lcd_data), .lcd_rs_o(lcd_rs), .lcd_rw_o(lcd_rw), .lcd_en_o(lcd_en),
    .state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state
  logic [8:0] exp_q[$];
  int         rises_q[$];
  int         n_pass = 0;
  int         n_total = 0;
  int         cyc = 0;
  logic       en_prev = 1'b0;
  logic       done_prev = 1'b0;
  int         pulse_cnt = 0;
  int         last_pulse_len = 0;
  int         done_cyc = -1;
  logic [8:0] rise_byte = '0;
  logic       both_ready = 1'b0;
  logic       early_ready = 1'b0;
  logic       stab_err = 1'b0;
  logic       rw_err = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Bus monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      cyc       = 0;
      en_prev   = 1'b0;
      done_prev = 1'b0;
    end else begin
      cyc++;
      if (lcd_rw) rw_err = 1'b1;
      if (req0_ready && req1_ready) both_ready = 1'b1;
      if ((req0_ready || req1_ready) && !init_done) early_ready = 1'b1;
      if (lcd_en && !en_prev) begin
        rises_q.push_back(cyc);
        pulse_cnt = 1;
        rise_byte = {lcd_rs, lcd_data};
        chk("write_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("bus_byte", int'({lcd_rs, lcd_data}), int'(exp_q.pop_front()));
      end else if (lcd_en) begin
        pulse_cnt++;
        if ({lcd_rs, lcd_data} != rise_byte) stab_err = 1'b1;
      end else if (en_prev) begin
        last_pulse_len = pulse_cnt;
      end
      if (init_done && !done_prev) done_cyc = cyc;
      en_prev   = lcd_en;
      done_prev = init_done;
    end
  end

  // driver: offer one byte on a port, return the accept edge and bus state there
  task automatic do_send(input int port, input logic rs, input logic [7:0] data,
                         output int acc_cyc, output logic [8:0] acc_bus, output logic acc_rdy);
    logic got;
    got = 1'b0;
    acc_cyc = -1;
    acc_bus = '0;
    acc_rdy = 1'b0;
    @(negedge clk);
    if (port == 0) begin req0_valid = 1'b1; req0_rs = rs; req0_data = data; end
    else           begin req1_valid = 1'b1; req1_rs = rs; req1_data = data; end
    for (int i = 0; i < 400; i++) begin
      #1;
      if ((port == 0) ? req0_ready : req1_ready) begin got = 1'b1; break; end
      @(negedge clk);
    end
    chk($sformatf("accept_p%0d", port), int'(got), 1);
    if (got) begin
      @(posedge clk);
      #2;
      acc_cyc = cyc;
      acc_bus = {lcd_rs, lcd_data};
      acc_rdy = req0_ready | req1_ready;
    end
    if (port == 0) req0_valid = 1'b0;
    else           req1_valid = 1'b0;
  endtask

  task automatic wait_idle(output int idle_cyc);
    idle_cyc = -1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #2;
      if (!busy) begin idle_cyc = cyc; break; end
    end
    chk("idle_reached", int'(idle_cyc >= 0), 1);
  endtask

  task automatic wait_init_done();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #2;
      if (init_done) begin seen = 1'b1; break; end
    end
    chk("init_done_reached", int'(seen), 1);
  endtask

  task automatic push_init();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h06});
  endtask

  typedef struct {
    int         port;
    logic       rs;
    logic [7:0] data;
    int         exec_cyc;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int         acc, idle_c;
    logic [8:0] abus;
    logic       ardy;
    int         a0[4];
    int         a1[4];
    logic [8:0] ab0, ab1;
    logic       ar0, ar1;
    logic       en_seen;

    vecs[0] = '{0, 1'b1, 8'h41, EXEC};
    vecs[1] = '{1, 1'b0, 8'h01, LONG};
    vecs[2] = '{1, 1'b0, 8'h80, EXEC};
    vecs[3] = '{1, 1'b1, 8'h01, EXEC};
    vecs[4] = '{0, 1'b0, 8'h02, LONG};
    vecs[5] = '{1, 1'b0, 8'h03, LONG};
    vecs[6] = '{0, 1'b0, 8'h04, EXEC};
    vecs[7] = '{1, 1'b0, 8'h00, EXEC};

    // reset with a port-0 request already pending
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h50;
    req1_valid = 1'b0; req1_rs = 1'b0; req1_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_lcd_en", int'(lcd_en), 0);
    chk("rst_lcd_rw", int'(lcd_rw), 0);
    chk("rst_lcd_rs", int'(lcd_rs), 0);
    chk("rst_lcd_data", int'(lcd_data), 0);
    chk("rst_ready0", int'(req0_ready), 0);
    chk("rst_ready1", int'(req1_ready), 0);
    chk("rst_init_done", int'(init_done), 0);
    chk("rst_busy", int'(busy), 1);

    push_init();
    exp_q.push_back({1'b1, 8'h50});
    rst_n = 1'b1;
    do_send(0, 1'b1, 8'h50, acc, abus, ardy);
    chk("preinit_accept_cyc", acc, 108);
    chk("preinit_no_early_ready", int'(early_ready), 0);
    chk("init_rise_count", int'(rises_q.size() >= 4), 1);
    if (rises_q.size() >= 4) begin
      chk("init_rise0_cyc", rises_q[0], POWERON + SETUP);
      chk("init_rise1_cyc", rises_q[1], 35);
      chk("init_rise2_cyc", rises_q[2], 52);
      chk("init_rise3_after_long", rises_q[3], 93);
    end
    chk("init_done_cyc", done_cyc, 107);
    wait_idle(idle_c);
    chk("preinit_busy_len", idle_c - acc, SETUP + PULSE + HOLD + EXEC);

    // single-port writes, normal and long execution waits
    for (int v = 0; v < 8; v++) begin
      exp_q.push_back({vecs[v].rs, vecs[v].data});
      do_send(vecs[v].port, vecs[v].rs, vecs[v].data, acc, abus, ardy);
      chk($sformatf("v%0d_bus_at_accept", v), int'(abus), int'({vecs[v].rs, vecs[v].data}));
      chk($sformatf("v%0d_ready_after_accept", v), int'(ardy), 0);
      wait_idle(idle_c);
      chk($sformatf("v%0d_en_rise_offset", v), rises_q[$] - acc, SETUP);
      chk($sformatf("v%0d_pulse_len", v), last_pulse_len, PULSE);
      chk($sformatf("v%0d_busy_len", v), idle_c - acc, SETUP + PULSE + HOLD + vecs[v].exec_cyc);
      chk($sformatf("v%0d_bus_held", v), int'({lcd_rs, lcd_data}), int'({vecs[v].rs, vecs[v].data}));
    end

    // round-robin with both ports continuously requesting
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({1'b1, 8'h41 + 8'(i)});
      exp_q.push_back({1'b1, 8'h30 + 8'(i)});
    end
    both_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) do_send(0, 1'b1, 8'h41 + 8'(i), a0[i], ab0, ar0);
      end
      begin
        for (int i = 0; i < 4; i++) do_send(1, 1'b1, 8'h30 + 8'(i), a1[i], ab1, ar1);
      end
    join
    wait_idle(idle_c);
    chk("rr_all_written", exp_q.size(), 0);
    chk("rr_never_both_ready", int'(both_ready), 0);
    chk("rr_back_to_back_spacing", a1[0] - a0[0], SETUP + PULSE + HOLD + EXEC + 1);

    // reset while EN is high
    exp_q.push_back({1'b1, 8'h5A});
    do_send(0, 1'b1, 8'h5A, acc, abus, ardy);
    en_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #3;
      if (lcd_en) begin en_seen = 1'b1; break; end
    end
    chk("midpulse_en_seen", int'(en_seen), 1);
    rst_n = 1'b0;
    #1;
    chk("midpulse_rst_en", int'(lcd_en), 0);
    chk("midpulse_rst_busy", int'(busy), 1);
    chk("midpulse_rst_init_done", int'(init_done), 0);
    chk("midpulse_rst_data", int'(lcd_data), 0);
    rises_q.delete();
    exp_q.delete();
    push_init();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_init_done();
    chk("reinit_done_cyc", done_cyc, 107);
    chk("reinit_rise0_cyc", (rises_q.size() > 0) ? rises_q[0] : -1, POWERON + SETUP);
    repeat (40) @(posedge clk);
    #2;
    chk("reinit_no_resend", rises_q.size(), 4);
    chk("reinit_all_written", exp_q.size(), 0);

    chk("data_stable_in_pulse", int'(stab_err), 0);
    chk("rw_always_low", int'(rw_err), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule
